// File: rtl/mix_columns_stream.sv
// ---------------------------------------------------------------------------
// mix_columns_stream
//   AES/Rijndael MixColumns / InvMixColumns engine with valid/ready handshakes
//   on both sides. A block of NB 32-bit columns is latched on acceptance and
//   mixed COLS_PER_CYCLE columns per clock in a work buffer. The finished block
//   is then copied to state_out in one step, so state_out never shows a
//   partially mixed block. The mode (inv) is captured per block.
//
// Parameters
//   NB              state columns (4, 6 or 8)
//   COLS_PER_CYCLE  columns mixed per clock; must divide NB
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous reset, active-high
//   in_valid   in   state_in / inv valid
//   in_ready   out  engine can accept a block this cycle
//   inv        in   0 = MixColumns, 1 = InvMixColumns
//   state_in   in   column c = [32c+31:32c], row r byte = [32c+8r +: 8]
//   out_valid  out  state_out holds a finished block
//   out_ready  in   consumer takes the block
//   state_out  out  result, same packing as state_in
//   busy       out  FSM not IDLE
// ---------------------------------------------------------------------------
module mix_columns_stream #(
  parameter int NB             = 4,
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            inv,
  input  logic [32*NB-1:0] state_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [32*NB-1:0] state_out,
  output logic            busy
);

  localparam int NGRP = NB / COLS_PER_CYCLE;
  localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;

  // Illegal configurations stop elaboration instead of building a broken engine.
  if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
    $error("mix_columns_stream: NB must be 4, 6 or 8");
  end
  if (COLS_PER_CYCLE < 1 || (NB % COLS_PER_CYCLE) != 0) begin : g_bad_cpc
    $error("mix_columns_stream: COLS_PER_CYCLE must divide NB");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    HOLD    = 2'd2
  } state_e;

  // -------------------------------------------------------------------------
  // GF(2^8) arithmetic, reduction polynomial 0x11b
  // -------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Product of x with the matrix coefficient at circulant position pos.
  // Encrypt row {02,03,01,01}; decrypt row {0e,0b,0d,09} from xtime chains.
  function automatic logic [7:0] coef_mul(input logic [7:0] x,
                                          input logic [1:0] pos,
                                          input logic       dec);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    if (!dec) begin
      case (pos)
        2'd0:    return x2;
        2'd1:    return x2 ^ x;
        default: return x;
      endcase
    end else begin
      case (pos)
        2'd0:    return x8 ^ x4 ^ x2;
        2'd1:    return x8 ^ x2 ^ x;
        2'd2:    return x8 ^ x4 ^ x;
        default: return x8 ^ x;
      endcase
    end
  endfunction

  // b[r] = XOR_k coef[(k-r) mod 4] * a[k]; the 2-bit cast performs the mod 4.
  function automatic logic [31:0] mix_column(input logic [31:0] col,
                                             input logic        dec);
    logic [31:0] res;
    res = '0;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 4; k++) begin
        res[8*r +: 8] = res[8*r +: 8] ^ coef_mul(col[8*k +: 8], 2'(k - r), dec);
      end
    end
    return res;
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e                 state_q, state_d;
  logic [GW-1:0]          grp_q, grp_d;
  logic                   inv_q, inv_d;
  logic [NB-1:0][31:0]    work_q, work_d;
  logic [NB-1:0][31:0]    out_q, out_d;
  logic                   out_valid_q, out_valid_d;

  logic [COLS_PER_CYCLE-1:0][31:0] grp_cols;
  logic [NB-1:0][31:0]             work_mixed;
  logic                            accept;

  // Only COLS_PER_CYCLE mixers exist; the current group is muxed into them
  // and the results are written back in place (columns are independent).
  always_comb begin
    // NOTE: every always_comb target gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    grp_cols = '0;
    for (int j = 0; j < COLS_PER_CYCLE; j++) begin
      for (int g = 0; g < NGRP; g++) begin
        if (grp_q == GW'(g)) grp_cols[j] = work_q[g*COLS_PER_CYCLE + j];
      end
    end

    work_mixed = work_q;
    for (int c = 0; c < NB; c++) begin
      if (grp_q == GW'(c / COLS_PER_CYCLE)) begin
        work_mixed[c] = mix_column(grp_cols[c % COLS_PER_CYCLE], inv_q);
      end
    end
  end

  // In HOLD the engine is ready as soon as the consumer frees the output,
  // which lets back-to-back blocks enter without an IDLE cycle.
  assign in_ready = !rst && ((state_q == IDLE) || (state_q == HOLD && out_ready));
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    grp_d       = grp_q;
    inv_d       = inv_q;
    work_d      = work_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          work_d  = state_in;
          inv_d   = inv;
          grp_d   = '0;
          state_d = COMPUTE;
        end
      end

      COMPUTE: begin
        work_d = work_mixed;
        if (grp_q == GW'(NGRP - 1)) begin
          out_d       = work_mixed;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end else begin
          grp_d = grp_q + GW'(1);
        end
      end

      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (accept) begin
            work_d  = state_in;
            inv_d   = inv;
            grp_d   = '0;
            state_d = COMPUTE;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grp_q       <= '0;
      inv_q       <= 1'b0;
      // NOTE: the work buffer is cleared on reset on purpose, so a discarded
      // block can never leak into a later result.
      work_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grp_q       <= grp_d;
      inv_q       <= inv_d;
      work_q      <= work_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign state_out = out_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != IDLE);

endmodule
